vram_sram_ctrl: RTL and testbench
=================================

Name: vram_sram_ctrl

Overview:
- Synthesisable, parametrised controller for an external asynchronous SRAM (IS61C5128-class), used as display memory.
- Arbitrates between a video-fetch port (reads only, fixed priority) and a CPU port (read/write).
- Generates CE/OE/WE strobes with programmable wait states, including write setup and hold cycles.
- Sits between the CGA/MDA display logic and the board-level VRAM pins, replacing direct pin drive.

Parameters:
AW, 19, SRAM address width
DW, 8, SRAM data width
RD_WAIT, 1, extra cycles OE is held low before read data is sampled (0..7)
WR_WAIT, 2, cycles WE is held low (1..7)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vid_req  in  1  video read request, level; held until vid_ack
vid_addr  in  AW  video read address
vid_ack  out  1  one-cycle pulse; vid_rdata valid the same cycle
vid_rdata  out  DW  video read data, held until next video ack
cpu_req  in  1  CPU request, level; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  CPU read data, held until next CPU read ack
sram_addr  out  AW  SRAM address pins
sram_dout  out  DW  data driven to SRAM
sram_doe  out  1  tristate enable for sram_dout (top level builds the inout)
sram_din  in  DW  data sampled from SRAM
sram_ce_l  out  1  chip enable, active low
sram_oe_l  out  1  output enable, active low
sram_we_l  out  1  write enable, active low

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous, active-high, on port reset.
- Registered outputs: all SRAM outputs are registered; no combinational path from req to pins.
- Reset values:
  - sram_ce_l = sram_oe_l = sram_we_l = 1, sram_doe = 0.
  - sram_addr = 0, sram_dout = 0.
  - vid_ack = cpu_ack = 0, vid_rdata = cpu_rdata = 0.
  - FSM returns to IDLE.
- Reset mid-cycle aborts the access: strobes are deasserted on the next edge and no ack is issued.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE:
  - Arbitration is evaluated only in IDLE, and vid_req wins whenever both requests are high.
  - Grant vid_req (read): latch address, drop CE and OE, go to RD.
  - Grant cpu_req with cpu_we=0: same as a video read.
  - Grant cpu_req with cpu_we=1: latch address and data, drop CE, set doe=1, go to WR_SETUP.
- RD:
  - Counter runs RD_WAIT+1 cycles with CE/OE low.
  - On the last cycle, sram_din is sampled into the granted port's rdata, that port's ack pulses, and CE/OE return high.
  - Return to IDLE.
  - Read latency from grant to ack = RD_WAIT+2 clocks.
- WR_SETUP: one cycle with address, data and CE stable and WE high; then drop WE and go to WR_PULSE.
- WR_PULSE: WE low for exactly WR_WAIT cycles; then WE high, go to WR_HOLD.
- WR_HOLD:
  - One cycle with address, data and doe unchanged (0 ns hold margin); cpu_ack pulses.
  - Next edge: CE high, doe=0, go to IDLE.
- Bus turnaround: doe is never 1 while OE is low. Each access ends with a return to IDLE (at least one cycle with CE high), so back-to-back accesses have a turnaround cycle.
- Latched operands: address and data are latched at grant. Changes to request inputs during an access are ignored.
- No starvation: a pending CPU request is served after at most one video access. A "cpu_pending_skip" flag forces a CPU grant if video won the previous arbitration while cpu_req was high.
- Widths: the counter is 3 bits, and parameter values outside the stated ranges are unsupported. vid_ack and cpu_ack are never high in the same cycle.

Test Plan:
- Reset then idle: after reset, with no requests → strobes all 1, doe=0, no acks for 20 cycles.
- Video read, RD_WAIT=1, vid_addr=0x00010 preloaded 0x5A → CE/OE low for 2 cycles; vid_ack on cycle 3 after grant; vid_rdata=0x5A.
- CPU write, addr 0x00020, data 0xC3, WR_WAIT=2 → WE high 1 cycle, low 2, high 1 with doe=1 throughout; cpu_ack in the WR_HOLD cycle; a subsequent CPU read returns 0xC3.
- Simultaneous vid_req and cpu_req, both held continuously → grants alternate V, C, V, C. CE high at least 1 cycle between accesses; never two acks in the same cycle.
- Reset asserted during WR_PULSE → next edge: WE=1, CE=1, doe=0, no cpu_ack; FSM in IDLE.
- Bus contention check: over 1000 random mixed requests → assertion that doe=1 and sram_oe_l=0 never occur together, and all reads match a shadow memory model.

Source files
------------

// File: rtl/vram_sram_ctrl.sv
// Display-memory controller for an asynchronous SRAM: video reads take priority, CPU reads/writes are interleaved.
// Read: grant to ack in RD_WAIT+2 clocks. Write: grant to ack in WR_WAIT+2 clocks. Requests wait as level signals until acked.
module vram_sram_ctrl #(
    parameter int AW      = 19,
    parameter int DW      = 8,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dout,
    output logic          sram_doe,
    input  logic [DW-1:0] sram_din,
    output logic          sram_ce_l,
    output logic          sram_oe_l,
    output logic          sram_we_l
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_PULSE = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;

    localparam logic [2:0] RD_LAST = 3'(RD_WAIT);
    localparam logic [2:0] WR_LAST = 3'(WR_WAIT - 1);

    logic [2:0] state;
    logic [2:0] cnt;
    logic       rd_is_cpu;
    logic       cpu_skip;
    logic       vid_live;
    logic       cpu_live;
    logic       vid_go;
    logic       cpu_go;

    // A request is still high during its own ack cycle; mask it there so it is not granted twice.
    always_comb begin
        vid_live = vid_req & ~vid_ack;
        cpu_live = cpu_req & ~cpu_ack;
        cpu_go   = cpu_live & (~vid_live | cpu_skip);
        vid_go   = vid_live & ~cpu_go;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            rd_is_cpu <= 1'b0;
            cpu_skip  <= 1'b0;
            sram_addr <= '0;
            sram_dout <= '0;
            sram_doe  <= 1'b0;
            sram_ce_l <= 1'b1;
            sram_oe_l <= 1'b1;
            sram_we_l <= 1'b1;
            vid_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            vid_rdata <= '0;
            cpu_rdata <= '0;
        end else begin
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= 3'd0;
                    if (vid_go) begin
                        sram_addr <= vid_addr;
                        sram_ce_l <= 1'b0;
                        sram_oe_l <= 1'b0;
                        rd_is_cpu <= 1'b0;
                        // CPU lost this round while waiting: it wins the next one.
                        cpu_skip  <= cpu_live;
                        state     <= S_RD;
                    end else if (cpu_go) begin
                        sram_addr <= cpu_addr;
                        sram_ce_l <= 1'b0;
                        rd_is_cpu <= 1'b1;
                        cpu_skip  <= 1'b0;
                        if (cpu_we) begin
                            sram_dout <= cpu_wdata;
                            sram_doe  <= 1'b1;
                            state     <= S_WR_SETUP;
                        end else begin
                            sram_oe_l <= 1'b0;
                            state     <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (cnt == RD_LAST) begin
                        sram_ce_l <= 1'b1;
                        sram_oe_l <= 1'b1;
                        state     <= S_IDLE;
                        if (rd_is_cpu) begin
                            cpu_rdata <= sram_din;
                            cpu_ack   <= 1'b1;
                        end else begin
                            vid_rdata <= sram_din;
                            vid_ack   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_WR_SETUP: begin
                    sram_we_l <= 1'b0;
                    cnt       <= 3'd0;
                    state     <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (cnt == WR_LAST) begin
                        sram_we_l <= 1'b1;
                        cpu_ack   <= 1'b1;
                        state     <= S_WR_HOLD;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_WR_HOLD: begin
                    sram_ce_l <= 1'b1;
                    sram_doe  <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    sram_ce_l <= 1'b1;
                    sram_oe_l <= 1'b1;
                    sram_we_l <= 1'b1;
                    sram_doe  <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_sram_ctrl.sv
// Directed table plus hand sequences and a mixed random run against an async SRAM model and shadow memory.
module tb_vram_sram_ctrl;
    localparam int AW = 19;
    localparam int DW = 8;
    localparam logic [1:0] OP_VRD = 2'd0;
    localparam logic [1:0] OP_CRD = 2'd1;
    localparam logic [1:0] OP_CWR = 2'd2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack;
    logic [DW-1:0] vid_rdata;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dout;
    logic          sram_doe;
    logic [DW-1:0] sram_din;
    logic          sram_ce_l;
    logic          sram_oe_l;
    logic          sram_we_l;

    int total = 0;
    int bad = 0;
    logic mon_en = 1'b0;
    logic mem_init = 1'b1;

    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] shadow [0:15];

    vram_sram_ctrl #(.AW(AW), .DW(DW), .RD_WAIT(1), .WR_WAIT(2)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din),
        .sram_ce_l(sram_ce_l), .sram_oe_l(sram_oe_l), .sram_we_l(sram_we_l)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(int i);
        logic [7:0] b;
        b = 8'(i);
        return (i == 16) ? 8'h5A : (b ^ 8'hA5);
    endfunction

    // Async SRAM: drives data only while CE and OE are low, captures while CE and WE are low.
    assign sram_din = (!sram_ce_l && !sram_oe_l) ? mem[sram_addr] : 8'hEE;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= pat(i);
        end else if (!sram_ce_l && !sram_we_l && sram_doe) begin
            mem[sram_addr] <= sram_dout;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (sram_doe && !sram_oe_l) begin
                bad++;
                $display("FAIL contention t=%0t doe=%0b oe_l=%0b required not both active", $time, sram_doe, sram_oe_l);
            end
            total++;
            if (vid_ack && cpu_ack) begin
                bad++;
                $display("FAIL dual_ack t=%0t vid_ack=%0b cpu_ack=%0b required at most one", $time, vid_ack, cpu_ack);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [1:0] op, input logic [AW-1:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output int lat);
        logic got;
        if (op == OP_VRD) begin
            vid_addr = addr;
            vid_req  = 1'b1;
        end else begin
            cpu_addr  = addr;
            cpu_we    = (op == OP_CWR);
            cpu_wdata = wd;
            cpu_req   = 1'b1;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            got = (op == OP_VRD) ? vid_ack : cpu_ack;
        end
        rd = (op == OP_VRD) ? vid_rdata : cpu_rdata;
        vid_req = 1'b0;
        cpu_req = 1'b0;
        if (!got) lat = -1;
        else if (op == OP_CWR && addr < 16) shadow[addr[3:0]] = wd;
        tick();
        tick();
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        logic [7:0]    exp_data;
        int            exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic vid_driver(input int n);
        int wcnt;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(1, 3)) tick();
            vid_addr = AW'($urandom_range(0, 15));
            vid_req  = 1'b1;
            wcnt = 0;
            do begin tick(); wcnt++; end while (!vid_ack && wcnt < 100);
            if (!vid_ack) begin
                bad++;
                total++;
                $display("FAIL rand_vid_timeout t=%0t actual=no_ack required=ack", $time);
                vid_req = 1'b0;
                return;
            end
            chk("rand_vid_data", 32'(vid_rdata), 32'(shadow[vid_addr[3:0]]));
            vid_req = 1'b0;
        end
    endtask

    task automatic cpu_driver(input int n);
        int wcnt;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(1, 3)) tick();
            cpu_addr  = AW'($urandom_range(0, 15));
            cpu_we    = ($urandom_range(0, 1) == 1);
            cpu_wdata = 8'($urandom_range(0, 255));
            cpu_req   = 1'b1;
            wcnt = 0;
            do begin tick(); wcnt++; end while (!cpu_ack && wcnt < 100);
            if (!cpu_ack) begin
                bad++;
                total++;
                $display("FAIL rand_cpu_timeout t=%0t actual=no_ack required=ack", $time);
                cpu_req = 1'b0;
                return;
            end
            if (cpu_we) shadow[cpu_addr[3:0]] = cpu_wdata;
            else chk("rand_cpu_data", 32'(cpu_rdata), 32'(shadow[cpu_addr[3:0]]));
            cpu_req = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] rd;
        int lat;
        logic [3:0] exp_we;
        logic [3:0] exp_ack;
        int nack;
        logic [3:0] who;
        logic [3:0] exp_who;

        for (int i = 0; i < 16; i++) shadow[i] = pat(i);
        vecs[0] = '{OP_VRD, 19'h00010, 8'h00, 8'h5A, 3};
        vecs[1] = '{OP_CWR, 19'h00020, 8'hC3, 8'h00, 4};
        vecs[2] = '{OP_CRD, 19'h00020, 8'h00, 8'hC3, 3};
        vecs[3] = '{OP_VRD, 19'h00020, 8'h00, 8'hC3, 3};
        vecs[4] = '{OP_CWR, 19'h7FFFF, 8'h81, 8'h00, 4};
        vecs[5] = '{OP_VRD, 19'h7FFFF, 8'h00, 8'h81, 3};
        vecs[6] = '{OP_CWR, 19'h00000, 8'hFF, 8'h00, 4};
        vecs[7] = '{OP_CRD, 19'h00000, 8'h00, 8'hFF, 3};
        vecs[8] = '{OP_CRD, 19'h00011, 8'h00, 8'hB4, 3};

        tick();
        mem_init = 1'b0;
        tick();
        chk("rst_ce", 32'(sram_ce_l), 1);
        chk("rst_oe", 32'(sram_oe_l), 1);
        chk("rst_we", 32'(sram_we_l), 1);
        chk("rst_doe", 32'(sram_doe), 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_dout", 32'(sram_dout), 0);
        chk("rst_acks", {30'd0, vid_ack, cpu_ack}, 0);
        chk("rst_rdata", {16'd0, vid_rdata, cpu_rdata}, 0);
        reset = 1'b0;
        mon_en = 1'b1;

        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_pins", {28'd0, sram_ce_l, sram_oe_l, sram_we_l, sram_doe}, 32'hE);
            chk("idle_acks", {30'd0, vid_ack, cpu_ack}, 0);
        end

        for (int v = 0; v < 9; v++) begin
            access(vecs[v].op, vecs[v].addr, vecs[v].wdata, rd, lat);
            chk($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
            if (vecs[v].op != OP_CWR) chk($sformatf("vec%0d_data", v), 32'(rd), 32'(vecs[v].exp_data));
        end
        chk("vid_rdata_held", 32'(vid_rdata), 32'h81);
        chk("cpu_rdata_held", 32'(cpu_rdata), 32'hB4);

        // Video read strobe shape: CE/OE low two cycles, ack in the third.
        vid_addr = 19'h00010;
        vid_req  = 1'b1;
        tick();
        chk("vrd_c1", {30'd0, sram_ce_l, sram_oe_l}, 0);
        tick();
        chk("vrd_c2", {29'd0, sram_ce_l, sram_oe_l, vid_ack}, 0);
        tick();
        chk("vrd_c3", {29'd0, sram_ce_l, sram_oe_l, vid_ack}, 32'h7);
        chk("vrd_data", 32'(vid_rdata), 32'h5A);
        vid_req = 1'b0;
        tick();

        // Write strobe shape: WE high, low, low, high with doe held and ack in the hold cycle.
        exp_we  = 4'b1001;
        exp_ack = 4'b1000;
        cpu_addr = 19'h00021; cpu_we = 1'b1; cpu_wdata = 8'h3C; cpu_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("wr_c%0d_we", c), 32'(sram_we_l), 32'(exp_we[c]));
            chk($sformatf("wr_c%0d_ack", c), 32'(cpu_ack), 32'(exp_ack[c]));
            chk($sformatf("wr_c%0d_ce_doe", c), {30'd0, sram_ce_l, sram_doe}, 1);
            chk($sformatf("wr_c%0d_bus", c), {5'd0, sram_addr, sram_dout}, {5'd0, 19'h00021, 8'h3C});
        end
        cpu_req = 1'b0;
        tick();
        chk("wr_end", {30'd0, sram_ce_l, sram_doe}, 32'h2);
        tick();
        access(OP_CRD, 19'h00021, 8'h00, rd, lat);
        chk("wr_readback", 32'(rd), 32'h3C);

        // Both requests held: grants alternate video, cpu, video, cpu.
        vid_addr = 19'h00010; vid_req = 1'b1;
        cpu_addr = 19'h00020; cpu_we = 1'b0; cpu_req = 1'b1;
        nack = 0;
        who = 4'b0000;
        exp_who = 4'b1010;
        for (int c = 0; c < 60 && nack < 4; c++) begin
            tick();
            if (vid_ack || cpu_ack) begin
                who[nack] = cpu_ack;
                chk($sformatf("alt%0d_ce_gap", nack), 32'(sram_ce_l), 1);
                if (cpu_ack) chk($sformatf("alt%0d_cdata", nack), 32'(cpu_rdata), 32'hC3);
                else chk($sformatf("alt%0d_vdata", nack), 32'(vid_rdata), 32'h5A);
                nack++;
            end
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        chk("alt_count", 32'(nack), 4);
        chk("alt_order", 32'(who), 32'(exp_who));
        tick();
        tick();

        // Reset during the write pulse aborts the access.
        cpu_addr = 19'h00030; cpu_we = 1'b1; cpu_wdata = 8'h77; cpu_req = 1'b1;
        tick();
        tick();
        chk("abort_in_pulse", 32'(sram_we_l), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cpu_req = 1'b0;
        chk("abort_pins", {28'd0, sram_ce_l, sram_we_l, sram_doe, cpu_ack}, 32'hC);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("abort_no_ack", 32'(cpu_ack), 0);
        end
        access(OP_VRD, 19'h00010, 8'h00, rd, lat);
        chk("abort_idle_lat", 32'(lat), 3);
        chk("abort_idle_data", 32'(rd), 32'h5A);

        fork
            vid_driver(500);
            cpu_driver(500);
        join
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
